pixel_stream_sink: RTL

Receiving end of the pixel-stream path: accepts a valid/ready pixel stream tagged with start-of-frame and end-of-line markers, recovers each pixel's X/Y coordinate, and presents data plus coordinates on a registered output port. It complements the raster counter that generates coordinates on the transmit side, and checks framing so that downstream math and display blocks see a consistent raster. Framing errors are reported as single-cycle pulses, and the block resynchronises on the next start-of-frame.

---
 rtl/pixel_stream_pkg.sv | 24 ++
 rtl/pixel_coord_tracker.sv | 50 +++++
 rtl/pixel_stream_sink.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_pkg.sv
// rtl/pixel_stream_pkg.sv - shared types, default geometry and helpers for the pixel-stream sink path
package pixel_stream_pkg;

    localparam int DEFAULT_WIDTH  = 1024;
    localparam int DEFAULT_HEIGHT = 768;
    localparam int DEFAULT_DATA_W = 24;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data;
        logic                      sof;
        logic                      eol;
    } pixel_beat_t;

    // Coordinate width that stays legal for degenerate one-pixel dimensions.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_coord_tracker.sv
// rtl/pixel_coord_tracker.sv - X/Y raster counter with advance, line wrap and restart-from-origin
module pixel_coord_tracker
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int HEIGHT   = DEFAULT_HEIGHT,
    localparam int XW      = coord_w(WIDTH),
    localparam int YW      = coord_w(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_advance,
    input  logic          i_restart,
    input  logic          i_eol,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last_x,
    output logic          o_last_y,
    output logic          o_last_frame
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    // Outputs describe the beat being presented now; a restart re-bases it at the origin.
    assign o_x          = i_restart ? '0 : r_x;
    assign o_y          = i_restart ? '0 : r_y;
    assign o_last_x     = (o_x == X_LAST);
    assign o_last_y     = (o_y == Y_LAST);
    assign o_last_frame = o_last_x && o_last_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (i_eol || o_last_x) begin
                r_x <= '0;
                r_y <= o_last_y ? '0 : o_y + YW'(1);
            end else begin
                r_x <= o_x + XW'(1);
                r_y <= o_y;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_sink.sv
// rtl/pixel_stream_sink.sv - framed pixel-stream receiver with X/Y recovery; ERR_COUNT_EN adds err_count
module pixel_stream_sink
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int HEIGHT  = DEFAULT_HEIGHT,
    parameter int DATA_W  = DEFAULT_DATA_W,
    localparam int XW     = coord_w(WIDTH),
    localparam int YW     = coord_w(HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [XW-1:0]     out_x,
    output logic [YW-1:0]     out_y,
    output logic              frame_done,
    output logic              err_early_eol,
    output logic              err_late_eol,
    output logic              err_sof
`ifdef ERR_COUNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_expect_sof;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [XW-1:0]       r_out_x;
    logic [YW-1:0]       r_out_y;
    logic                r_frame_done;
    logic                r_err_early;
    logic                r_err_late;
    logic                r_err_sof;

    logic                w_accept;
    logic                w_hunt_sof;
    logic                w_drop;
    logic                w_resync;
    logic                w_restart;
    logic                w_emit;
    logic                w_early;
    logic                w_late;
    logic [XW-1:0]       w_cur_x;
    logic [YW-1:0]       w_cur_y;
    logic                w_last_x;
    logic                w_last_y;
    logic                w_last_frame;

    pixel_coord_tracker #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .i_advance    (w_emit),
        .i_restart    (w_restart),
        .i_eol        (in_eol),
        .o_x          (w_cur_x),
        .o_y          (w_cur_y),
        .o_last_x     (w_last_x),
        .o_last_y     (w_last_y),
        .o_last_frame (w_last_frame)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            HUNT:    if (w_accept && in_sof) w_next_state = RUN;
            RUN:     if (w_accept && w_drop) w_next_state = HUNT;
            default: w_next_state = HUNT;
        endcase
    end

    always_comb begin
        in_ready   = rst || (r_state == HUNT) || !r_out_valid || out_ready;
        w_accept   = in_valid && in_ready;
        w_hunt_sof = (r_state == HUNT) && in_sof;
        w_drop     = (r_state == RUN) && r_expect_sof && !in_sof;
        w_resync   = (r_state == RUN) && !r_expect_sof && in_sof;
        w_restart  = w_hunt_sof || w_resync;
        w_emit     = w_accept && (w_hunt_sof || ((r_state == RUN) && !w_drop));
    end

    // Origin beats (HUNT capture or resync) only honour in_eol as an early line end.
    assign w_early = in_eol && !w_last_x;
    assign w_late  = !in_eol && w_last_x && !w_restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_frame_done <= 1'b0;
            r_err_early  <= 1'b0;
            r_err_late   <= 1'b0;
            r_err_sof    <= 1'b0;
            r_expect_sof <= 1'b0;
        end else begin
            r_frame_done <= w_emit && w_last_frame;
            r_err_early  <= w_emit && w_early;
            r_err_late   <= w_emit && w_late;
            r_err_sof    <= w_accept && (w_drop || w_resync);
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data;
                r_out_x     <= w_cur_x;
                r_out_y     <= w_cur_y;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A line end on the last row closes the frame; the next beat must open one.
            if (w_emit) begin
                r_expect_sof <= w_last_y && (in_eol || w_last_x);
            end else if (w_accept && w_drop) begin
                r_expect_sof <= 1'b0;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_x         = r_out_x;
    assign out_y         = r_out_y;
    assign frame_done    = r_frame_done;
    assign err_early_eol = r_err_early;
    assign err_late_eol  = r_err_late;
    assign err_sof       = r_err_sof;

`ifdef ERR_COUNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if ((r_err_early || r_err_late || r_err_sof) && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
